// File: rtl/mips_rf_operand_ctrl.sv
// Operand controller for the 32x32 MIPS register file.
// Hides the synchronous read latency and bypasses writeback data.
module mips_rf_operand_ctrl #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          iss_valid,
   output logic          iss_ready,
   input  logic [AW-1:0] iss_rs,
   input  logic [AW-1:0] iss_rt,
   output logic          op_valid,
   input  logic          op_ready,
   output logic [DW-1:0] op_a,
   output logic [DW-1:0] op_b,
   input  logic          wb_valid,
   input  logic [AW-1:0] wb_dr,
   input  logic [DW-1:0] wb_data,
   output logic          rf_regw,
   output logic [AW-1:0] rf_dr,
   output logic [DW-1:0] rf_din,
   output logic [AW-1:0] rf_sr1,
   output logic [AW-1:0] rf_sr2,
   input  logic [DW-1:0] rf_rd1,
   input  logic [DW-1:0] rf_rd2
);

   typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

   state_t        state_q;
   logic [AW-1:0] rs_q, rt_q;
   logic          byp_a_q, byp_b_q;
   logic [DW-1:0] byp_a_dat_q, byp_b_dat_q;
   logic [DW-1:0] op_a_q, op_b_q;
   logic          op_valid_q;

   logic          accept;
   logic          hit_iss_a, hit_iss_b;
   logic          hit_cap_a, hit_cap_b;
   logic [DW-1:0] op_a_d, op_b_d;

   // Handshake, write path, read address steering and operand selection
   always_comb begin
      iss_ready = (state_q == IDLE) ||
                  (state_q == VALID && op_ready);
      accept    = iss_valid && iss_ready;
      rf_regw   = wb_valid && (wb_dr != '0);
      rf_dr     = wb_dr;
      rf_din    = wb_data;
      rf_sr1    = iss_ready ? iss_rs : rs_q;
      rf_sr2    = iss_ready ? iss_rt : rt_q;
      hit_iss_a = rf_regw && (wb_dr == iss_rs);
      hit_iss_b = rf_regw && (wb_dr == iss_rt);
      hit_cap_a = rf_regw && (wb_dr == rs_q);
      hit_cap_b = rf_regw && (wb_dr == rt_q);
      if (rs_q == '0)   op_a_d = '0;
      else if (hit_cap_a) op_a_d = wb_data;
      else if (byp_a_q) op_a_d = byp_a_dat_q;
      else              op_a_d = rf_rd1;
      if (rt_q == '0)   op_b_d = '0;
      else if (hit_cap_b) op_b_d = wb_data;
      else if (byp_b_q) op_b_d = byp_b_dat_q;
      else              op_b_d = rf_rd2;
   end

   // Issue FSM: capture sources, load operands, hold them current while stalled
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         op_valid_q  <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         byp_a_q     <= 1'b0;
         byp_b_q     <= 1'b0;
         byp_a_dat_q <= '0;
         byp_b_dat_q <= '0;
      end else begin
         if (accept) begin
            rs_q        <= iss_rs;
            rt_q        <= iss_rt;
            byp_a_q     <= hit_iss_a;
            byp_b_q     <= hit_iss_b;
            byp_a_dat_q <= wb_data;
            byp_b_dat_q <= wb_data;
         end
         unique case (state_q)
            IDLE: begin
               if (accept) state_q <= FETCH;
            end
            FETCH: begin
               state_q    <= VALID;
               op_valid_q <= 1'b1;
               op_a_q     <= op_a_d;
               op_b_q     <= op_b_d;
            end
            VALID: begin
               if (op_ready) begin
                  op_valid_q <= 1'b0;
                  state_q    <= iss_valid ? FETCH : IDLE;
               end else begin
                  if (hit_cap_a) op_a_q <= wb_data;
                  if (hit_cap_b) op_b_q <= wb_data;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign op_valid = op_valid_q;
   assign op_a     = op_a_q;
   assign op_b     = op_b_q;

endmodule

// File: tb/tb_mips_rf_operand_ctrl.sv
// Directed bench for mips_rf_operand_ctrl with a behavioural
// register file (synchronous read, pre-write value on collision).
module tb_mips_rf_operand_ctrl;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          CLK = 1'b0;
   logic          RST;
   logic          iss_valid;
   logic          iss_ready;
   logic [AW-1:0] iss_rs, iss_rt;
   logic          op_valid;
   logic          op_ready;
   logic [DW-1:0] op_a, op_b;
   logic          wb_valid;
   logic [AW-1:0] wb_dr;
   logic [DW-1:0] wb_data;
   logic          rf_regw;
   logic [AW-1:0] rf_dr;
   logic [DW-1:0] rf_din;
   logic [AW-1:0] rf_sr1, rf_sr2;
   logic [DW-1:0] rf_rd1, rf_rd2;

   logic [DW-1:0] mem [32];

   int checks = 0;
   int errors = 0;

   mips_rf_operand_ctrl #(.DW(DW), .AW(AW)) dut (
      .CLK(CLK), .RST(RST),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_rs(iss_rs), .iss_rt(iss_rt),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_a(op_a), .op_b(op_b),
      .wb_valid(wb_valid), .wb_dr(wb_dr), .wb_data(wb_data),
      .rf_regw(rf_regw), .rf_dr(rf_dr), .rf_din(rf_din),
      .rf_sr1(rf_sr1), .rf_sr2(rf_sr2),
      .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
   );

   always #5 CLK = ~CLK;

   // register file: reads latch at the edge and see the old contents
   always @(posedge CLK) begin
      rf_rd1 <= mem[rf_sr1];
      rf_rd2 <= mem[rf_sr2];
      if (rf_regw) mem[rf_dr] <= rf_din;
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] r, input logic [DW-1:0] d);
      wb_valid = 1'b1; wb_dr = r; wb_data = d;
      tick();
      wb_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      RST = 1'b1; iss_valid = 1'b0; iss_rs = '0; iss_rt = '0;
      op_ready = 1'b0; wb_valid = 1'b0; wb_dr = '0; wb_data = '0;
      tick(); tick();
      RST = 1'b0;
      #1;
      chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
      chk("rst_op_a", op_a, 32'd0);
      chk("rst_op_b", op_b, 32'd0);
      chk("rst_iss_ready", {31'd0, iss_ready}, 32'd1);

      // preload via writeback
      wb_valid = 1'b1; wb_dr = 5'd5; wb_data = 32'h11111111;
      #1;
      chk("wb_regw", {31'd0, rf_regw}, 32'd1);
      chk("wb_dr", {27'd0, rf_dr}, 32'd5);
      chk("wb_din", rf_din, 32'h11111111);
      tick();
      wb_valid = 1'b0;
      wr(5'd7, 32'h1);
      wr(5'd1, 32'h1);
      wr(5'd2, 32'h2);
      wr(5'd3, 32'h5);
      wr(5'd9, 32'h99);

      // 1: basic read rs=5 rt=0
      iss_valid = 1'b1; iss_rs = 5'd5; iss_rt = 5'd0;
      #1;
      chk("t1_ready_idle", {31'd0, iss_ready}, 32'd1);
      chk("t1_sr1", {27'd0, rf_sr1}, 32'd5);
      tick();
      iss_valid = 1'b0; iss_rs = 5'd17;
      #1;
      chk("t1_fetch_valid", {31'd0, op_valid}, 32'd0);
      chk("t1_fetch_ready", {31'd0, iss_ready}, 32'd0);
      chk("t1_fetch_sr1", {27'd0, rf_sr1}, 32'd5);
      tick();
      chk("t1_valid", {31'd0, op_valid}, 32'd1);
      chk("t1_op_a", op_a, 32'h11111111);
      chk("t1_op_b", op_b, 32'd0);
      op_ready = 1'b1;
      #1;
      chk("t1_ready_valid", {31'd0, iss_ready}, 32'd1);
      tick();
      op_ready = 1'b0;
      chk("t1_drop", {31'd0, op_valid}, 32'd0);

      // 2: write to R0 suppressed
      wb_valid = 1'b1; wb_dr = 5'd0; wb_data = 32'hDEADBEEF;
      #1;
      chk("t2_regw", {31'd0, rf_regw}, 32'd0);
      tick();
      wb_valid = 1'b0;
      chk("t2_mem0", mem[0], 32'd0);
      iss_valid = 1'b1; iss_rs = 5'd0; iss_rt = 5'd0;
      tick();
      iss_valid = 1'b0;
      tick();
      chk("t2_op_a", op_a, 32'd0);
      chk("t2_op_b", op_b, 32'd0);
      op_ready = 1'b1; tick(); op_ready = 1'b0;

      // 3a: write on accept edge bypasses stale read
      iss_valid = 1'b1; iss_rs = 5'd7; iss_rt = 5'd5;
      wb_valid = 1'b1; wb_dr = 5'd7; wb_data = 32'hA5A5A5A5;
      tick();
      iss_valid = 1'b0; wb_valid = 1'b0;
      tick();
      chk("t3_byp_a", op_a, 32'hA5A5A5A5);
      chk("t3_byp_b", op_b, 32'h11111111);
      op_ready = 1'b1; tick(); op_ready = 1'b0;
      // 3b: write during FETCH wins
      iss_valid = 1'b1; iss_rs = 5'd7; iss_rt = 5'd7;
      tick();
      iss_valid = 1'b0;
      wb_valid = 1'b1; wb_dr = 5'd7; wb_data = 32'hB;
      tick();
      wb_valid = 1'b0;
      chk("t3_fetch_a", op_a, 32'hB);
      chk("t3_fetch_b", op_b, 32'hB);
      op_ready = 1'b1; tick(); op_ready = 1'b0;

      // 4: stall with update of held operands
      iss_valid = 1'b1; iss_rs = 5'd3; iss_rt = 5'd3;
      tick();
      iss_valid = 1'b0;
      tick();
      chk("t4_init_a", op_a, 32'h5);
      chk("t4_init_b", op_b, 32'h5);
      tick();
      chk("t4_hold_valid", {31'd0, op_valid}, 32'd1);
      wr(5'd3, 32'h42);
      chk("t4_upd_a", op_a, 32'h42);
      chk("t4_upd_b", op_b, 32'h42);
      tick(); tick();
      chk("t4_held_a", op_a, 32'h42);
      chk("t4_held_valid", {31'd0, op_valid}, 32'd1);
      chk("t4_held_ready", {31'd0, iss_ready}, 32'd0);
      op_ready = 1'b1;
      tick();
      chk("t4_release", {31'd0, op_valid}, 32'd0);

      // 5: back-to-back, one request per two cycles
      iss_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         iss_rs = (i % 2 == 0) ? 5'd1 : 5'd2;
         iss_rt = (i % 2 == 0) ? 5'd2 : 5'd1;
         #1;
         chk("t5_ready_hi", {31'd0, iss_ready}, 32'd1);
         if (i > 0) begin
            chk("t5_pulse", {31'd0, op_valid}, 32'd1);
            chk("t5_a", op_a, (i % 2 == 0) ? 32'h2 : 32'h1);
            chk("t5_b", op_b, (i % 2 == 0) ? 32'h1 : 32'h2);
         end
         tick();
         chk("t5_ready_lo", {31'd0, iss_ready}, 32'd0);
         chk("t5_gap", {31'd0, op_valid}, 32'd0);
         tick();
      end
      iss_valid = 1'b0;
      chk("t5_last_v", {31'd0, op_valid}, 32'd1);
      chk("t5_last_a", op_a, 32'h2);
      chk("t5_last_b", op_b, 32'h1);
      tick();
      op_ready = 1'b0;
      chk("t5_done", {31'd0, op_valid}, 32'd0);

      // 6: reset during FETCH discards the request
      iss_valid = 1'b1; iss_rs = 5'd9; iss_rt = 5'd9;
      tick();
      iss_valid = 1'b0; RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("t6_valid", {31'd0, op_valid}, 32'd0);
      chk("t6_ready", {31'd0, iss_ready}, 32'd1);
      chk("t6_op_a", op_a, 32'd0);
      tick();
      chk("t6_valid2", {31'd0, op_valid}, 32'd0);
      iss_valid = 1'b1;
      tick();
      iss_valid = 1'b0;
      tick();
      chk("t6_pres_a", op_a, 32'h99);
      chk("t6_pres_b", op_b, 32'h99);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
